// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary constants: per-stage payload widths, bubble control words,
// and the bit layout of the control word carried between stages.
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    localparam int unsigned IFID_DATA_W  = 64;   // PC, INSTR
    localparam int unsigned IFID_CTRL_W  = 1;
    localparam int unsigned IDEX_DATA_W  = 128;  // PC, DATA1, DATA2, IMMEDIATE
    localparam int unsigned IDEX_CTRL_W  = 24;
    localparam int unsigned EXMEM_DATA_W = 96;   // PC, ALU result, DATA2
    localparam int unsigned EXMEM_CTRL_W = 24;
    localparam int unsigned MEMWB_DATA_W = 64;   // ALU result, load data
    localparam int unsigned MEMWB_CTRL_W = 24;

    // Control word layout shared by the ID/EX, EX/MEM and MEM/WB boundaries
    localparam int unsigned CTRL_RD_LSB     = 0;
    localparam int unsigned CTRL_RD_W       = 5;
    localparam int unsigned CTRL_ALU_OP_LSB = 5;
    localparam int unsigned CTRL_ALU_OP_W   = 5;
    localparam int unsigned CTRL_BJ_LSB     = 10;
    localparam int unsigned CTRL_BJ_W       = 4;
    localparam int unsigned CTRL_RW_LSB     = 14;
    localparam int unsigned CTRL_RW_W       = 4;
    localparam int unsigned CTRL_WB_SEL_LSB = 18;
    localparam int unsigned CTRL_WB_SEL_W   = 2;
    localparam int unsigned CTRL_REG_WE_BIT = 20;

    localparam logic [IFID_CTRL_W-1:0]  IFID_BUBBLE_CTRL  = '0;
    localparam logic [IDEX_CTRL_W-1:0]  IDEX_BUBBLE_CTRL  = '0;
    localparam logic [EXMEM_CTRL_W-1:0] EXMEM_BUBBLE_CTRL = '0;
    localparam logic [MEMWB_CTRL_W-1:0] MEMWB_BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_slot.sv
// One valid+data+ctrl holding register; load wins over clear, reset wins over both.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            ctrl_q  <= ctrl_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic valid/ready stage register with optional skid slot, flush-to-bubble and global freeze.
// The head beat always lives in the main slot M; the skid slot S only backs it up.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W      = IDEX_DATA_W,
    parameter int unsigned CTRL_W      = IDEX_CTRL_W,
    parameter bit          SKID        = 1'b1,
    parameter              BUBBLE_CTRL = {CTRL_W{1'b0}},
    parameter bit          CLEAR_DATA  = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              BUSYWAIT,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [CTRL_W-1:0] IN_CTRL,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [OCC_W-1:0]  OCCUPANCY
);

    if ($bits(BUBBLE_CTRL) != CTRL_W) begin : g_bubble_width_check
        $error("elastic_pipe_reg: BUBBLE_CTRL width does not match CTRL_W");
    end

    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data, s_data, m_data_in;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_in;
    logic              in_xfer, out_xfer, promote, m_load, m_clear;

    always_comb begin
        if (SKID) IN_READY = !s_valid && !BUSYWAIT;
        else      IN_READY = (!m_valid || OUT_READY) && !BUSYWAIT;
    end

    assign in_xfer  = IN_VALID & IN_READY & ~BUSYWAIT & ~FLUSH;
    assign out_xfer = m_valid & OUT_READY & ~BUSYWAIT & ~FLUSH;

    // A consumed head is refilled from S first to keep ordering; otherwise from the input
    assign promote   = out_xfer & s_valid;
    assign m_load    = promote | (in_xfer & (~m_valid | out_xfer));
    assign m_clear   = FLUSH | (out_xfer & ~m_load);
    assign m_data_in = promote ? s_data : IN_DATA;
    assign m_ctrl_in = promote ? s_ctrl : IN_CTRL;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .CLK     (CLK),
        .RESET   (RESET),
        .load_i  (m_load),
        .clear_i (m_clear),
        .data_i  (m_data_in),
        .ctrl_i  (m_ctrl_in),
        .valid_o (m_valid),
        .data_o  (m_data),
        .ctrl_o  (m_ctrl)
    );

    if (SKID) begin : g_skid
        logic s_load, s_clear;

        assign s_load  = in_xfer & m_valid & ~out_xfer;
        assign s_clear = FLUSH | promote;

        pipe_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_skid (
            .CLK     (CLK),
            .RESET   (RESET),
            .load_i  (s_load),
            .clear_i (s_clear),
            .data_i  (IN_DATA),
            .ctrl_i  (IN_CTRL),
            .valid_o (s_valid),
            .data_o  (s_data),
            .ctrl_o  (s_ctrl)
        );
    end else begin : g_no_skid
        assign s_valid = 1'b0;
        assign s_data  = '0;
        assign s_ctrl  = '0;
    end

    assign OUT_VALID = m_valid;
    assign OUT_CTRL  = m_valid ? m_ctrl : BUBBLE_CTRL;
    assign OUT_DATA  = (CLEAR_DATA && !m_valid) ? '0 : m_data;
    assign OCCUPANCY = {1'b0, m_valid} + {1'b0, s_valid};

endmodule
